// File: rtl/depth_to_cloud_pkg.sv
// Shared types, widths and the saturation helper for the depth-to-point-cloud stage.
package depth_to_cloud_pkg;

  localparam int SHIFT_BIT_NUM = 24;
  localparam int DATA_DEPTH_BW = 16;
  localparam int CLOUD_BW      = 42;
  localparam int FX_BW         = 35;
  localparam int CLOUD_FRAC    = SHIFT_BIT_NUM;
  localparam int SIZE_BW       = 10;
  localparam int PROD_BW       = FX_BW + DATA_DEPTH_BW;
  localparam int FULL_BW       = PROD_BW + FX_BW;

  typedef struct packed {
    logic signed [CLOUD_BW-1:0] x;
    logic signed [CLOUD_BW-1:0] y;
    logic signed [CLOUD_BW-1:0] z;
  } point_3d_t;

  typedef enum logic {D2C_IDLE, D2C_ACTIVE} d2c_state_e;

  typedef struct packed {
    logic [SIZE_BW-1:0]       h_size;
    logic [SIZE_BW-1:0]       v_size;
    logic signed [FX_BW-1:0]  inv_fx;
    logic signed [FX_BW-1:0]  inv_fy;
    logic signed [FX_BW-1:0]  cx;
    logic signed [FX_BW-1:0]  cy;
    logic [DATA_DEPTH_BW-1:0] depth_max;
    logic [DATA_DEPTH_BW-1:0] depth_min;
  } cfg_t;

  typedef struct packed {
    logic [DATA_DEPTH_BW-1:0] depth;
    logic                     pt_valid;
    logic                     sof;
    logic                     eof;
  } beat_t;

  // Drops the fraction of a full-width product and clamps it into the signed output range.
  function automatic logic signed [CLOUD_BW-1:0] sat_cloud(input logic signed [FULL_BW-1:0] v);
    logic signed [FULL_BW-1:0] s;
    s = v >>> CLOUD_FRAC;
    if ((&s[FULL_BW-1:CLOUD_BW-1]) || !(|s[FULL_BW-1:CLOUD_BW-1]))
      return s[CLOUD_BW-1:0];
    else if (s[FULL_BW-1])
      return {1'b1, {(CLOUD_BW-1){1'b0}}};
    else
      return {1'b0, {(CLOUD_BW-1){1'b1}}};
  endfunction

endpackage

// File: rtl/depth_cloud_mul.sv
// Two-stage signed multiply: offset*depth, then *inverse focal, rescaled and saturated.
module depth_cloud_mul
  import depth_to_cloud_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic signed [FX_BW-1:0]    i_d,
  input  logic [DATA_DEPTH_BW-1:0]   i_depth,
  input  logic signed [FX_BW-1:0]    i_inv_f,
  output logic signed [CLOUD_BW-1:0] o_p
);

  logic signed [PROD_BW-1:0]  p_d, p_q;
  logic signed [FX_BW-1:0]    inv_f_q;
  logic signed [FULL_BW-1:0]  full;
  logic signed [CLOUD_BW-1:0] res_d, res_q;

  always_comb begin
    p_d   = $signed({{DATA_DEPTH_BW{i_d[FX_BW-1]}}, i_d}) * $signed({{FX_BW{1'b0}}, i_depth});
    full  = $signed({{FX_BW{p_q[PROD_BW-1]}}, p_q}) * $signed({{PROD_BW{inv_f_q[FX_BW-1]}}, inv_f_q});
    res_d = sat_cloud(full);
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, whatever the statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      p_q     <= '0;
      inv_f_q <= '0;
      res_q   <= '0;
    end else if (i_en) begin
      p_q     <= p_d;
      inv_f_q <= i_inv_f;
      res_q   <= res_d;
    end
  end

  assign o_p = res_q;

endmodule

// File: rtl/depth_to_cloud.sv
// Back-projects a raster depth stream into 3D points, one per pixel, through a 3-stage pipeline.
module depth_to_cloud
  import depth_to_cloud_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_disable,
  input  logic [SIZE_BW-1:0]         i_h_size,
  input  logic [SIZE_BW-1:0]         i_v_size,
  input  logic signed [FX_BW-1:0]    i_inv_fx,
  input  logic signed [FX_BW-1:0]    i_inv_fy,
  input  logic signed [FX_BW-1:0]    i_cx,
  input  logic signed [FX_BW-1:0]    i_cy,
  input  logic [DATA_DEPTH_BW-1:0]   i_depth_max,
  input  logic [DATA_DEPTH_BW-1:0]   i_depth_min,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_sof,
  input  logic [DATA_DEPTH_BW-1:0]   i_depth,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic signed [CLOUD_BW-1:0] o_x,
  output logic signed [CLOUD_BW-1:0] o_y,
  output logic signed [CLOUD_BW-1:0] o_z,
  output logic                       o_pt_valid,
  output logic                       o_sof,
  output logic                       o_eof,
  output logic                       o_frame_err
);

  d2c_state_e                 state_q, state_d;
  logic [SIZE_BW-1:0]         u_q, u_d, v_q, v_d, pix_u, pix_v;
  cfg_t                       cfg_q, cfg_d, cfg_in, cfg_eff;
  logic                       frame_err_q, frame_err_d;
  logic                       en, accept, sof_take, take, last, depth_ok;
  beat_t                      s1_d, s1_q, s2_q, s3_q;
  logic                       s1_vld_q, s2_vld_q, s3_vld_q;
  logic signed [FX_BW-1:0]    du_d, dv_d, du_q, dv_q, inv_fx_q, inv_fy_q;
  logic signed [CLOUD_BW-1:0] z_d, z_q, x_mul, y_mul;
  point_3d_t                  pt;

  assign cfg_in = '{h_size: i_h_size, v_size: i_v_size, inv_fx: i_inv_fx, inv_fy: i_inv_fy,
                    cx: i_cx, cy: i_cy, depth_max: i_depth_max, depth_min: i_depth_min};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    u_d         = u_q;
    v_d         = v_q;
    cfg_d       = cfg_q;
    s1_d        = '0;
    depth_ok    = 1'b0;
    en          = ~s3_vld_q | i_ready;
    // IDLE also waits on en so a sof never lands on top of a stalled point.
    o_ready     = ~i_rst & en & ((state_q == D2C_ACTIVE) | ~i_disable);
    accept      = i_valid & o_ready;
    sof_take    = accept & i_sof;
    take        = accept & (i_sof | (state_q == D2C_ACTIVE));
    cfg_eff     = sof_take ? cfg_in : cfg_q;
    pix_u       = i_sof ? '0 : u_q;
    pix_v       = i_sof ? '0 : v_q;
    last        = (pix_u == cfg_eff.h_size - SIZE_BW'(1)) && (pix_v == cfg_eff.v_size - SIZE_BW'(1));
    frame_err_d = sof_take & (state_q == D2C_ACTIVE);
    if (sof_take) cfg_d = cfg_in;
    if (take) begin
      state_d = last ? D2C_IDLE : D2C_ACTIVE;
      if (pix_u == cfg_eff.h_size - SIZE_BW'(1)) begin
        u_d = '0;
        v_d = pix_v + SIZE_BW'(1);
      end else begin
        u_d = pix_u + SIZE_BW'(1);
        v_d = pix_v;
      end
      depth_ok      = (i_depth != '0) && (i_depth >= cfg_eff.depth_min) && (i_depth <= cfg_eff.depth_max);
      // Invalid pixels carry depth 0 so x, y and z all collapse to zero downstream.
      s1_d.depth    = depth_ok ? i_depth : '0;
      s1_d.pt_valid = depth_ok;
      s1_d.sof      = i_sof;
      s1_d.eof      = last;
    end
    du_d = $signed({{(FX_BW-SIZE_BW-CLOUD_FRAC){1'b0}}, pix_u, {CLOUD_FRAC{1'b0}}}) - cfg_eff.cx;
    dv_d = $signed({{(FX_BW-SIZE_BW-CLOUD_FRAC){1'b0}}, pix_v, {CLOUD_FRAC{1'b0}}}) - cfg_eff.cy;
    z_d  = $signed({{(CLOUD_BW-DATA_DEPTH_BW-CLOUD_FRAC){1'b0}}, s2_q.depth, {CLOUD_FRAC{1'b0}}});
  end

  // NOTE: datapath registers are reset along with control so every output reads 0 out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= D2C_IDLE;
      u_q         <= '0;
      v_q         <= '0;
      cfg_q       <= '0;
      frame_err_q <= 1'b0;
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s3_vld_q    <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      du_q        <= '0;
      dv_q        <= '0;
      inv_fx_q    <= '0;
      inv_fy_q    <= '0;
      z_q         <= '0;
    end else begin
      state_q     <= state_d;
      u_q         <= u_d;
      v_q         <= v_d;
      cfg_q       <= cfg_d;
      frame_err_q <= frame_err_d;
      if (en) begin
        s1_vld_q <= take;
        s1_q     <= s1_d;
        du_q     <= du_d;
        dv_q     <= dv_d;
        inv_fx_q <= cfg_eff.inv_fx;
        inv_fy_q <= cfg_eff.inv_fy;
        s2_vld_q <= s1_vld_q;
        s2_q     <= s1_q;
        s3_vld_q <= s2_vld_q;
        s3_q     <= s2_q;
        z_q      <= z_d;
      end
    end
  end

  depth_cloud_mul u_mul_x (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(en),
    .i_d(du_q), .i_depth(s1_q.depth), .i_inv_f(inv_fx_q), .o_p(x_mul)
  );

  depth_cloud_mul u_mul_y (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(en),
    .i_d(dv_q), .i_depth(s1_q.depth), .i_inv_f(inv_fy_q), .o_p(y_mul)
  );

  assign pt          = '{x: x_mul, y: y_mul, z: z_q};
  assign o_x         = pt.x;
  assign o_y         = pt.y;
  assign o_z         = pt.z;
  assign o_valid     = s3_vld_q;
  assign o_pt_valid  = s3_q.pt_valid;
  assign o_sof       = s3_q.sof;
  assign o_eof       = s3_q.eof;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_depth_to_cloud.sv
// Randomized bench for depth_to_cloud against a wide-integer back-projection model.
module tb_depth_to_cloud;

  logic               i_clk = 1'b0;
  logic               i_rst, i_disable, i_valid, i_sof, i_ready;
  logic [9:0]         i_h_size, i_v_size;
  logic signed [34:0] i_inv_fx, i_inv_fy, i_cx, i_cy;
  logic [15:0]        i_depth_max, i_depth_min, i_depth;
  logic               o_ready, o_valid, o_pt_valid, o_sof, o_eof, o_frame_err;
  logic signed [41:0] o_x, o_y, o_z;

  depth_to_cloud dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_disable(i_disable), .i_h_size(i_h_size), .i_v_size(i_v_size),
    .i_inv_fx(i_inv_fx), .i_inv_fy(i_inv_fy), .i_cx(i_cx), .i_cy(i_cy),
    .i_depth_max(i_depth_max), .i_depth_min(i_depth_min), .i_valid(i_valid), .o_ready(o_ready),
    .i_sof(i_sof), .i_depth(i_depth), .o_valid(o_valid), .i_ready(i_ready),
    .o_x(o_x), .o_y(o_y), .o_z(o_z), .o_pt_valid(o_pt_valid), .o_sof(o_sof), .o_eof(o_eof),
    .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic signed [41:0] x;
    logic signed [41:0] y;
    logic signed [41:0] z;
    logic               pt_valid;
    logic               sof;
    logic               eof;
  } obs_t;

  localparam logic signed [127:0] MAXC = (128'sd1 <<< 41) - 128'sd1;
  localparam logic signed [127:0] MINC = -(128'sd1 <<< 41);
  localparam longint ONE = 64'sd1 <<< 24;

  obs_t got_q[$], exp_q[$];
  int   checks = 0, errors = 0;
  int   err_pulses = 0, exp_err_pulses = 0, stall_breaks = 0;
  bit   rand_ready = 1'b0;

  bit                 m_active = 1'b0;
  int                 mu, mv, m_h, m_v, m_dmin, m_dmax;
  logic signed [34:0] m_cx, m_cy, m_ifx, m_ify;

  // ---------------- reference model ----------------
  function automatic logic signed [41:0] project(int c, int d, logic signed [34:0] off, logic signed [34:0] inv);
    logic signed [127:0] p, offw, invw;
    offw = off;
    invw = inv;
    p = (((128'(c)) <<< 24) - offw) * 128'(d) * invw;
    p = p >>> 24;
    if (p > MAXC) p = MAXC;
    else if (p < MINC) p = MINC;
    return p[41:0];
  endfunction

  task automatic model_accept(input bit sof, input int d);
    obs_t e;
    if (sof) begin
      if (m_active) exp_err_pulses++;
      m_active = 1'b1; mu = 0; mv = 0;
      m_h = i_h_size; m_v = i_v_size; m_cx = i_cx; m_cy = i_cy;
      m_ifx = i_inv_fx; m_ify = i_inv_fy; m_dmin = i_depth_min; m_dmax = i_depth_max;
    end else if (!m_active) begin
      return;
    end
    e = '0;
    if (d != 0 && d >= m_dmin && d <= m_dmax) begin
      e.pt_valid = 1'b1;
      e.x = project(mu, d, m_cx, m_ifx);
      e.y = project(mv, d, m_cy, m_ify);
      e.z = 42'(longint'(d) <<< 24);
    end
    e.sof = sof;
    e.eof = (mu == m_h - 1) && (mv == m_v - 1);
    exp_q.push_back(e);
    if (e.eof) m_active = 1'b0;
    else if (mu == m_h - 1) begin mu = 0; mv++; end
    else mu++;
  endtask

  // ---------------- monitor and ready driver ----------------
  initial begin
    obs_t cur, held;
    bit   held_vld;
    held_vld = 1'b0;
    held = '0;
    forever begin
      @(negedge i_clk);
      cur = '{o_x, o_y, o_z, o_pt_valid, o_sof, o_eof};
      if (i_rst) begin
        held_vld = 1'b0;
      end else begin
        if (held_vld && (!o_valid || cur !== held)) stall_breaks++;
        if (o_frame_err) err_pulses++;
        if (o_valid && i_ready) got_q.push_back(cur);
        held_vld = o_valid && !i_ready;
        held = cur;
      end
    end
  end

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_beat(input bit sof, input int d);
    bit acc, ok;
    ok = 1'b0;
    i_valid = 1'b1; i_sof = sof; i_depth = 16'(d);
    for (int c = 0; c < 200; c++) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
      if (acc) begin ok = 1'b1; break; end
    end
    i_valid = 1'b0; i_sof = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout sof=%0b depth=%0d got no o_ready want o_ready within 200 cycles", sof, d);
    end else begin
      model_accept(sof, d);
    end
  endtask

  task automatic set_cfg(input int h, input int v, input longint ifx, input longint ify,
                         input longint cx, input longint cy, input int dmin, input int dmax);
    i_h_size = 10'(h); i_v_size = 10'(v);
    i_inv_fx = 35'(ifx); i_inv_fy = 35'(ify); i_cx = 35'(cx); i_cy = 35'(cy);
    i_depth_min = 16'(dmin); i_depth_max = 16'(dmax);
  endtask

  task automatic start_test();
    got_q.delete(); exp_q.delete();
    err_pulses = 0; exp_err_pulses = 0; stall_breaks = 0;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (got_q.size() < exp_q.size() && c < 20000) begin @(posedge i_clk); c++; end
    repeat (8) @(posedge i_clk);
    #1;
    checks++;
    if (c >= 20000) begin
      errors++;
      $display("FAIL %s drain_timeout got %0d points want %0d", name, got_q.size(), exp_q.size());
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    return (got_q.size() == exp_q.size()) ? -1 : n;
  endfunction

  function automatic string fmt(obs_t p);
    return $sformatf("x=%0d y=%0d z=%0d pv=%0b sof=%0b eof=%0b", p.x, p.y, p.z, p.pt_valid, p.sof, p.eof);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b1; i_disable = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_depth = '0;
    set_cfg(4, 2, ONE, ONE, 0, 0, 1, 65535);
    repeat (3) @(posedge i_clk);
    i_disable = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst got %0b want 0", o_ready); end
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_disable = 1'b1;
    @(negedge i_clk);
    checks++;
    if ({o_valid, o_pt_valid, o_sof, o_eof, o_frame_err} !== 5'b0 || o_x !== 0 || o_y !== 0 || o_z !== 0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%0b %s err=%0b want all 0", o_valid,
               fmt('{o_x, o_y, o_z, o_pt_valid, o_sof, o_eof}), o_frame_err);
    end
    checks++;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_disabled got %0b want 0", o_ready); end
    i_disable = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_enabled got %0b want 1", o_ready); end
    @(posedge i_clk); #1;
  endtask

  task automatic test_basic();
    int idx;
    start_test();
    set_cfg(4, 2, ONE, ONE, 0, 0, 1, 65535);
    for (int i = 0; i < 8; i++) send_beat(i == 0, 100);
    wait_drain("basic");
    checks++;
    if (got_q.size() < 8 || got_q[7].x !== 42'(300 * ONE) || got_q[7].y !== 42'(100 * ONE) ||
        got_q[7].z !== 42'(100 * ONE) || got_q[7].pt_valid !== 1'b1 || got_q[7].eof !== 1'b1) begin
      errors++;
      $display("FAIL basic_pixel_3_1 got %0d points, last %s want x=%0d y=%0d z=%0d pv=1 eof=1",
               got_q.size(), (got_q.size() > 0) ? fmt(got_q[got_q.size()-1]) : "none",
               300 * ONE, 100 * ONE, 100 * ONE);
    end
    idx = first_diff();
    checks++;
    if (idx >= 0) begin
      errors++;
      $display("FAIL basic_seq[%0d] got %s want %s (count %0d/%0d)", idx, fmt(got_q[idx]), fmt(exp_q[idx]),
               got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_invalid_depth();
    int idx;
    int depths[8] = '{0, 49, 50, 1000, 1001, 100, 65535, 7};
    start_test();
    set_cfg(4, 2, ONE, ONE, ONE + 123, ONE + 123, 50, 1000);
    for (int i = 0; i < 8; i++) send_beat(i == 0, depths[i]);
    wait_drain("invalid_depth");
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i].pt_valid !== 1'b0 || got_q[i].x !== 0 || got_q[i].y !== 0 ||
          got_q[i].z !== 0) begin
        errors++;
        $display("FAIL invalid_depth_zero[%0d] got %s want pv=0 x=y=z=0", i,
                 (got_q.size() > i) ? fmt(got_q[i]) : "missing");
      end
    end
    idx = first_diff();
    checks++;
    if (idx >= 0) begin
      errors++;
      $display("FAIL invalid_depth_seq[%0d] got %s want %s (count %0d/%0d)", idx, fmt(got_q[idx]),
               fmt(exp_q[idx]), got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int idx, eofs;
    start_test();
    set_cfg(640, 8, ONE / 525, ONE / 530, 320 * ONE + (ONE / 2), 4 * ONE, 10, 3000);
    rand_ready = 1'b1;
    for (int i = 0; i < 640 * 8; i++) send_beat(i == 0, $urandom_range(0, 4000));
    wait_drain("back_to_back");
    rand_ready = 1'b0;
    eofs = 0;
    foreach (got_q[i]) if (got_q[i].eof) eofs++;
    checks++;
    if (got_q.size() != 640 * 8) begin
      errors++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), 640 * 8);
    end
    checks++;
    if (eofs != 1) begin errors++; $display("FAIL b2b_eof_count got %0d want 1", eofs); end
    checks++;
    if (stall_breaks != 0) begin errors++; $display("FAIL b2b_stall_stable got %0d changes want 0", stall_breaks); end
    idx = first_diff();
    checks++;
    if (idx >= 0) begin
      errors++;
      $display("FAIL b2b_seq[%0d] got %s want %s (count %0d/%0d)", idx, fmt(got_q[idx]), fmt(exp_q[idx]),
               got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_sof_restart();
    int idx;
    logic signed [41:0] want_x;
    start_test();
    set_cfg(4, 2, ONE, ONE, 0, 0, 1, 65535);
    for (int i = 0; i < 5; i++) send_beat(i == 0, 20 + i);
    i_cx = 35'(ONE);
    send_beat(1'b1, 77);
    for (int i = 1; i < 8; i++) send_beat(1'b0, 30 + i);
    wait_drain("sof_restart");
    checks++;
    if (err_pulses != 1 || exp_err_pulses != 1) begin
      errors++; $display("FAIL sof_restart_err_pulses got %0d want 1", err_pulses);
    end
    want_x = project(0, 77, 35'(ONE), 35'(ONE));
    checks++;
    if (got_q.size() < 6 || got_q[5].sof !== 1'b1 || got_q[5].x !== want_x || got_q[5].y !== 0) begin
      errors++;
      $display("FAIL sof_restart_pixel0 got %s want sof=1 x=%0d y=0",
               (got_q.size() > 5) ? fmt(got_q[5]) : "missing", want_x);
    end
    idx = first_diff();
    checks++;
    if (idx >= 0) begin
      errors++;
      $display("FAIL sof_restart_seq[%0d] got %s want %s (count %0d/%0d)", idx, fmt(got_q[idx]),
               fmt(exp_q[idx]), got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_saturation();
    int idx;
    start_test();
    set_cfg(640, 1, 1023 * ONE, ONE, 0, 0, 1, 65535);
    for (int i = 0; i < 640; i++) send_beat(i == 0, (i == 639) ? 65535 : $urandom_range(1, 65535));
    wait_drain("saturation");
    checks++;
    if (got_q.size() != 640 || got_q[639].x !== 42'h1FF_FFFF_FFFF || got_q[639].eof !== 1'b1) begin
      errors++;
      $display("FAIL saturation_x got %0d points, last %s want x=%0d eof=1", got_q.size(),
               (got_q.size() > 0) ? fmt(got_q[got_q.size()-1]) : "none", MAXC);
    end
    idx = first_diff();
    checks++;
    if (idx >= 0) begin
      errors++;
      $display("FAIL saturation_seq[%0d] got %s want %s (count %0d/%0d)", idx, fmt(got_q[idx]),
               fmt(exp_q[idx]), got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int idx;
    start_test();
    set_cfg(4, 2, ONE, ONE, 0, 0, 1, 65535);
    for (int i = 0; i < 3; i++) send_beat(i == 0, 500 + i);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %0b want 0", o_valid); end
    m_active = 1'b0;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) send_beat(1'b0, 600 + i);
    repeat (10) @(posedge i_clk);
    #1;
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL mid_reset_dropped got %0d points want 0", got_q.size()); end
    for (int i = 0; i < 8; i++) send_beat(i == 0, $urandom_range(1, 900));
    wait_drain("mid_reset");
    idx = first_diff();
    checks++;
    if (idx >= 0) begin
      errors++;
      $display("FAIL mid_reset_seq[%0d] got %s want %s (count %0d/%0d)", idx, fmt(got_q[idx]),
               fmt(exp_q[idx]), got_q.size(), exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid_depth();
    test_back_to_back();
    test_sof_restart();
    test_saturation();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
